parity_rx: RTL and testbench
============================

PARITY_RX -- requirements
Module: parity_rx

Interface
REQ-001 Parameter: DATA_W, 8, number of data bits per frame (legal range 2..16).
REQ-002 Parameter: ODD, 0, parity sense: 0 = even parity, 1 = odd parity.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: bit_en  input  1  bit strobe; rx_bit is sampled only on edges where bit_en=1.
REQ-006 Port: rx_bit  input  1  serial line; idle level 1.
REQ-007 Port: data_out  output  DATA_W  last received data word.
REQ-008 Port: out_valid  output  1  one-cycle pulse marking a completed frame.
REQ-009 Port: parity_err  output  1  parity mismatch flag for the frame flagged by out_valid.
REQ-010 Port: frame_err  output  1  stop-bit-not-1 flag for the frame flagged by out_valid.
REQ-011 Port: busy  output  1  high whenever the FSM is in any state other than IDLE.

Function
REQ-012 Frame format, in order: start bit (0), then DATA_W data bits LSB first, then 1 parity bit, then 1 stop bit (1).
REQ-013 FSM states: IDLE, DATA, PARITY, STOP; state changes only on edges where bit_en=1.
REQ-014 IDLE: bit_en=1 and rx_bit=0 -> DATA; clear the bit counter and the running XOR. bit_en=1 and rx_bit=1 -> stay in IDLE.
REQ-015 DATA: each strobe shifts rx_bit into shift register position [count] and XORs it into the running parity. After DATA_W strobes -> PARITY.
REQ-016 PARITY: on the strobe, store perr = running_xor ^ rx_bit ^ ODD (1 means mismatch), then -> STOP.
REQ-017 STOP: on the strobe -> IDLE; in the same edge, load data_out with the shift register, parity_err with perr, frame_err with ~rx_bit, and set out_valid=1.
REQ-018 out_valid is high for exactly one clk cycle (the cycle after the stop strobe), regardless of bit_en.
REQ-019 data_out, parity_err and frame_err hold their values until the next completed frame.
REQ-020 A frame with frame_err=1 is still reported; data_out is updated and out_valid pulses.
REQ-021 Cycles with bit_en=0 change no state other than clearing out_valid.
REQ-022 Back-to-back frames: a start bit on the strobe immediately after the stop strobe is accepted with no gap.
REQ-023 Bit counter width is ceil(log2(DATA_W+1)); the counter does not wrap inside a frame.
REQ-024 Latency: out_valid rises on the clk edge where the stop bit is sampled, i.e. it is visible in the cycle that follows.

Reset
REQ-025 While rst=1 at a clk edge: FSM -> IDLE; data_out=0, out_valid=0, parity_err=0, frame_err=0, busy=0; counter and running XOR are cleared.
REQ-026 rst has priority over bit_en. Reset during a frame abandons the frame with no out_valid pulse, and reception restarts at the next start bit.

Verification
REQ-027 DATA_W=8, ODD=0, with bit_en held at 1, send 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0, stop 1) -> one out_valid pulse, data_out=0xA5, parity_err=0, frame_err=0.
REQ-028 Send 0x07 with parity bit 0 and stop bit 1 -> data_out=0x07, parity_err=1, frame_err=0.
REQ-029 Send 0x3C with correct parity and stop bit 0 -> data_out=0x3C, parity_err=0, frame_err=1, and the next frame is received correctly.
REQ-030 Assert rst after 4 data bits of a frame -> no out_valid pulse, all outputs 0, busy=0; a following 0x5A frame is received correctly.
REQ-031 ODD=1, send 0x00 with parity bit 1, with bit_en asserted every 3rd cycle -> data_out=0x00, parity_err=0, and no state change on cycles with bit_en=0.
REQ-032 Send two frames back-to-back (0x81 then 0x7E) with no idle bits between them -> two out_valid pulses carrying 0x81 then 0x7E, with no errors.

Source files
------------

// File: rtl/parity_rx.sv
// -----------------------------------------------------------------------------
// parity_rx
//   Serial frame receiver driven by an external bit strobe. A frame is a start
//   bit (0), DATA_W data bits LSB first, one parity bit and one stop bit (1).
//   The receiver samples rx_bit only on clk edges where bit_en=1. Each
//   completed frame is reported with a one-cycle out_valid pulse, together
//   with its data word and its parity and framing error flags.
//
// Parameters
//   DATA_W      data bits per frame (2..16)
//   ODD         parity sense: 0 = even parity, 1 = odd parity
//
// Ports
//   clk         in   sole clock, rising edge
//   rst         in   synchronous, active-high reset (has priority over bit_en)
//   bit_en      in   bit strobe; rx_bit is sampled only when high
//   rx_bit      in   serial line, idles at 1
//   data_out    out  [DATA_W-1:0] data word of the last completed frame
//   out_valid   out  one-cycle pulse marking a completed frame
//   parity_err  out  parity mismatch for the frame flagged by out_valid
//   frame_err   out  stop bit was 0 for the frame flagged by out_valid
//   busy        out  high while a frame is being received (FSM not IDLE)
// -----------------------------------------------------------------------------
module parity_rx #(
   parameter int DATA_W = 8,
   parameter int ODD    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_en,
   input  logic              rx_bit,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int   CNT_W   = $clog2(DATA_W + 1);
   localparam logic ODD_BIT = (ODD != 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_e;

   state_e              state_q,      state_d;
   logic [CNT_W-1:0]    cnt_q,        cnt_d;
   logic                xor_q,        xor_d;
   logic [DATA_W-1:0]   shift_q,      shift_d;
   logic                perr_q,       perr_d;
   logic [DATA_W-1:0]   data_out_q,   data_out_d;
   logic                out_valid_q,  out_valid_d;
   logic                parity_err_q, parity_err_d;
   logic                frame_err_q,  frame_err_d;

   // Next-state and datapath logic. Everything holds unless a strobe arrives,
   // except out_valid which is a single-cycle pulse and drops on its own.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      xor_d        = xor_q;
      shift_d      = shift_q;
      perr_d       = perr_q;
      data_out_d   = data_out_q;
      out_valid_d  = 1'b0;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;

      if (bit_en) begin
         case (state_q)
            IDLE: begin
               if (!rx_bit) begin
                  state_d = DATA;
                  cnt_d   = '0;
                  xor_d   = 1'b0;
               end
            end
            DATA: begin
               // Explicit decode of the bit position keeps the index width
               // independent of the counter width.
               for (int i = 0; i < DATA_W; i++) begin
                  if (cnt_q == CNT_W'(i)) shift_d[i] = rx_bit;
               end
               xor_d = xor_q ^ rx_bit;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DATA_W - 1)) state_d = PARITY;
            end
            PARITY: begin
               // 1 means the received parity bit disagrees with the data.
               perr_d  = xor_q ^ rx_bit ^ ODD_BIT;
               state_d = STOP;
            end
            STOP: begin
               // A bad stop bit is still reported; only the flag differs.
               data_out_d   = shift_q;
               parity_err_d = perr_q;
               frame_err_d  = ~rx_bit;
               out_valid_d  = 1'b1;
               state_d      = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         xor_q        <= 1'b0;
         shift_q      <= '0;
         perr_q       <= 1'b0;
         data_out_q   <= '0;
         out_valid_q  <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         xor_q        <= xor_d;
         shift_q      <= shift_d;
         perr_q       <= perr_d;
         data_out_q   <= data_out_d;
         out_valid_q  <= out_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign data_out   = data_out_q;
   assign out_valid  = out_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_parity_rx.sv
// -----------------------------------------------------------------------------
// tb_parity_rx
//   Two receivers share the clock and reset: index 0 checks even parity,
//   index 1 odd parity. Frames are described as (data, parity bit, stop bit);
//   the expected report of each frame is computed from the frame itself by
//   counting ones, and queued for the monitor to match against out_valid.
// -----------------------------------------------------------------------------
module tb_parity_rx;

   localparam int DATA_W = 8;
   localparam int W      = DATA_W + 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic              bit_en     [2];
   logic              rx_bit     [2];
   logic [DATA_W-1:0] data_out   [2];
   logic              out_valid  [2];
   logic              parity_err [2];
   logic              frame_err  [2];
   logic              busy       [2];

   parity_rx #(.DATA_W(DATA_W), .ODD(0)) dut_even (
      .clk(clk), .rst(rst), .bit_en(bit_en[0]), .rx_bit(rx_bit[0]),
      .data_out(data_out[0]), .out_valid(out_valid[0]),
      .parity_err(parity_err[0]), .frame_err(frame_err[0]), .busy(busy[0])
   );

   parity_rx #(.DATA_W(DATA_W), .ODD(1)) dut_odd (
      .clk(clk), .rst(rst), .bit_en(bit_en[1]), .rx_bit(rx_bit[1]),
      .data_out(data_out[1]), .out_valid(out_valid[1]),
      .parity_err(parity_err[1]), .frame_err(frame_err[1]), .busy(busy[1])
   );

   // ---------------- scoreboard state ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] exp_q0[$];   // {parity_err, frame_err, data}
   logic [W-1:0] exp_q1[$];
   logic              exp_busy [2];
   logic [DATA_W-1:0] exp_data [2];
   logic              exp_perr [2];
   logic              exp_ferr [2];
   logic              prev_ov  [2];
   int  n_pushed = 0;
   int  n_seen   = 0;
   bit  mon_en   = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Frame-level reference: parity error when the count of ones over data and
   // parity bit does not have the parity the receiver expects.
   function automatic logic [W-1:0] model_frame(input int d, input logic [DATA_W-1:0] data,
                                                input logic pbit, input logic stop);
      int  ones;
      logic perr;
      ones = $countones(data) + int'(pbit);
      perr = ((ones % 2) != d);
      return {perr, ~stop, data};
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            logic [W-1:0] e;
            check($sformatf("busy%0d", d), 32'(busy[d]), 32'(exp_busy[d]));
            check($sformatf("data_out%0d", d), 32'(data_out[d]), 32'(exp_data[d]));
            check($sformatf("parity_err%0d", d), 32'(parity_err[d]), 32'(exp_perr[d]));
            check($sformatf("frame_err%0d", d), 32'(frame_err[d]), 32'(exp_ferr[d]));
            if (out_valid[d]) begin
               n_seen++;
               check($sformatf("ov_one_cycle%0d", d), 32'(prev_ov[d]), 32'd0);
               if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                  check($sformatf("unexpected_valid%0d", d), 32'd1, 32'd0);
               end else begin
                  e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                  check($sformatf("frame_word%0d", d),
                        32'({parity_err[d], frame_err[d], data_out[d]}), 32'(e));
               end
            end
            prev_ov[d] = out_valid[d];
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_model();
      for (int d = 0; d < 2; d++) begin
         exp_busy[d] = 1'b0;
         exp_data[d] = '0;
         exp_perr[d] = 1'b0;
         exp_ferr[d] = 1'b0;
      end
   endtask

   // gap idle cycles (bit_en=0, noisy line), then one strobe carrying b
   task automatic strobe(input int d, input logic b, input int gap);
      repeat (gap) begin
         bit_en[d] = 1'b0;
         rx_bit[d] = 1'($urandom);
         @(posedge clk); #1;
      end
      bit_en[d] = 1'b1;
      rx_bit[d] = b;
      @(posedge clk); #1;
      bit_en[d] = 1'b0;
      rx_bit[d] = 1'b1;
   endtask

   task automatic idle_strobes(input int d, input int n);
      repeat (n) strobe(d, 1'b1, 0);
   endtask

   // Reset with the strobe active on the receiving channel: reset must win.
   task automatic do_reset(input int d);
      rst       = 1'b1;
      bit_en[d] = 1'b1;
      rx_bit[d] = 1'($urandom);
      @(posedge clk); #1;
      rst       = 1'b0;
      bit_en[d] = 1'b0;
      rx_bit[d] = 1'b1;
      clear_model();
   endtask

   // abort_at >= 0 resets the design after that many data bits
   task automatic send_frame(input int d, input logic [DATA_W-1:0] data, input logic pbit,
                             input logic stop, input int gap, input int abort_at);
      logic [W-1:0] e;
      strobe(d, 1'b0, gap);
      exp_busy[d] = 1'b1;
      for (int i = 0; i < DATA_W; i++) begin
         if (i == abort_at) begin
            do_reset(d);
            return;
         end
         strobe(d, data[i], gap);
      end
      strobe(d, pbit, gap);
      strobe(d, stop, gap);
      e = model_frame(d, data, pbit, stop);
      exp_busy[d] = 1'b0;
      {exp_perr[d], exp_ferr[d], exp_data[d]} = e;
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      n_pushed++;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         bit_en[d]  = 1'b0;
         rx_bit[d]  = 1'b1;
         prev_ov[d] = 1'b0;
      end
      clear_model();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_data%0d", d), 32'(data_out[d]), 32'd0);
         check($sformatf("rst_valid%0d", d), 32'(out_valid[d]), 32'd0);
         check($sformatf("rst_perr%0d", d), 32'(parity_err[d]), 32'd0);
         check($sformatf("rst_ferr%0d", d), 32'(frame_err[d]), 32'd0);
         check($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
      end
      mon_en = 1'b1;

      // directed frames
      send_frame(0, 8'hA5, 1'b0, 1'b1, 0, -1);   // clean frame
      idle_strobes(0, 2);
      send_frame(0, 8'h07, 1'b0, 1'b1, 0, -1);   // wrong parity
      send_frame(0, 8'h3C, 1'b0, 1'b0, 0, -1);   // bad stop bit
      send_frame(0, 8'h12, 1'b0, 1'b1, 0, -1);   // recovers afterwards
      send_frame(0, 8'h99, 1'b0, 1'b1, 0, 4);    // reset mid-frame
      for (int d = 0; d < 2; d++) begin
         check($sformatf("abort_data%0d", d), 32'(data_out[d]), 32'd0);
         check($sformatf("abort_busy%0d", d), 32'(busy[d]), 32'd0);
      end
      send_frame(0, 8'h5A, 1'b0, 1'b1, 0, -1);
      send_frame(1, 8'h00, 1'b1, 1'b1, 2, -1);   // odd parity, strobe every 3rd cycle
      send_frame(0, 8'h81, 1'b0, 1'b1, 0, -1);   // back-to-back pair
      send_frame(0, 8'h7E, 1'b0, 1'b1, 0, -1);

      // randomized frames
      for (int n = 0; n < 60; n++) begin
         int d;
         int gap;
         int abort_at;
         d        = $urandom_range(0, 1);
         gap      = $urandom_range(0, 3);
         abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, DATA_W - 1) : -1;
         send_frame(d, DATA_W'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0),
                    gap, abort_at);
         idle_strobes(d, $urandom_range(0, 2));
      end

      repeat (4) @(posedge clk);
      #1;
      check("pending_q0", 32'(exp_q0.size()), 32'd0);
      check("pending_q1", 32'(exp_q1.size()), 32'd0);
      check("pulse_count", 32'(n_seen), 32'(n_pushed));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
